// File: rtl/fc8_vectored_irq_ctrl.sv
// Vectored interrupt controller: edge-detected maskable channels with
// fixed lowest-index-wins priority, a three-state IRQ handshake FSM,
// an independent unmaskable NMI latch and an optional interval timer.
// Optional feature macro: FC8_IRQ_TIMER_EN
//   When it is defined, the internal timer drives channel 0 and irq_src[0]
//   is ignored. When it is undefined, timer_count is tied to 0.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no request presented to the CPU
// S_REQ     | cpu_irq_req high, irq_vector tracks the current winner
// S_SERVICE | acknowledged channel in service, vector frozen until EOI
module fc8_vectored_irq_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int TIMER_W = 16
) (
    input  logic               clk_cpu,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               nmi_src,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic [NUM_IRQ-1:0] irq_clear,
    input  logic               timer_enable,
    input  logic [3:0]         timer_prescale,
    input  logic [TIMER_W-1:0] timer_reload,
    input  logic               cpu_irq_ack,
    input  logic               cpu_irq_eoi,
    input  logic               cpu_nmi_ack,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               cpu_irq_req,
    output logic               cpu_nmi_req,
    output logic [3:0]         irq_vector,
    output logic               irq_in_service,
    output logic [TIMER_W-1:0] timer_count
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] src_in;
    logic [NUM_IRQ-1:0] src_q, src_d, hist_q, hist_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] active, ack_clr;
    logic               nmi_src_q, nmi_src_d, nmi_hist_q, nmi_hist_d;
    logic               nmi_q, nmi_d;
    logic [3:0]         vector_q, vector_d, winner;
    logic               any_active, take_ack;

`ifdef FC8_IRQ_TIMER_EN
    logic [7:0]         presc_q, presc_d, presc_lim;
    logic [TIMER_W-1:0] tcount_q, tcount_d;
    logic               tevt_q, tevt_d;
    logic               unused_irq0;

    // Prescaler terminal count: 2^min(N,8) cycles per tick.
    always_comb begin
        presc_lim = 8'hFF;
        if (timer_prescale < 4'd8) presc_lim = (8'd1 << timer_prescale[2:0]) - 8'd1;
    end

    // Down-counter with reload on terminal count; event pulse on the wrap.
    always_comb begin
        presc_d  = 8'd0;
        tcount_d = timer_reload;
        tevt_d   = 1'b0;
        if (timer_enable) begin
            tcount_d = tcount_q;
            if (presc_q == presc_lim) begin
                if (tcount_q == '0) begin
                    tcount_d = timer_reload;
                    tevt_d   = 1'b1;
                end else begin
                    tcount_d = tcount_q - TIMER_W'(1);
                end
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
    end

    // Timer registers.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= 8'd0;
            tcount_q <= '0;
            tevt_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            tcount_q <= tcount_d;
            tevt_q   <= tevt_d;
        end
    end

    assign src_in      = {irq_src[NUM_IRQ-1:1], tevt_q};
    assign timer_count = tcount_q;
    assign unused_irq0 = irq_src[0];
`else
    logic unused_timer;

    assign src_in       = irq_src;
    assign timer_count  = '0;
    assign unused_timer = ^{timer_enable, timer_prescale, timer_reload};
`endif

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        active     = pending_q & irq_enable;
        any_active = |active;
        winner     = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) winner = 4'(i);
        end
    end

    // IRQ handshake next-state, vector tracking and acknowledge strobe.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        take_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_active) begin
                    state_d  = S_REQ;
                    vector_d = winner;
                end
            end
            S_REQ: begin
                if (!any_active) begin
                    state_d = S_IDLE;
                end else if (cpu_irq_ack) begin
                    state_d  = S_SERVICE;
                    take_ack = 1'b1;
                end else begin
                    vector_d = winner;
                end
            end
            S_SERVICE: begin
                if (cpu_irq_eoi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Edge detection and pending/NMI latch update; new edges win over clears.
    always_comb begin
        src_d      = src_in;
        hist_d     = src_q;
        nmi_src_d  = nmi_src;
        nmi_hist_d = nmi_src_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = take_ack && (vector_q == 4'(i));
        end
        pending_d = (pending_q & ~(irq_clear | ack_clr))
                  | (src_q & ~hist_q & irq_enable);
        nmi_d     = (nmi_src_q & ~nmi_hist_q) | (nmi_q & ~cpu_nmi_ack);
    end

    // Controller state registers.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vector_q   <= 4'd0;
            src_q      <= '0;
            hist_q     <= '0;
            pending_q  <= '0;
            nmi_src_q  <= 1'b0;
            nmi_hist_q <= 1'b0;
            nmi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vector_q   <= vector_d;
            src_q      <= src_d;
            hist_q     <= hist_d;
            pending_q  <= pending_d;
            nmi_src_q  <= nmi_src_d;
            nmi_hist_q <= nmi_hist_d;
            nmi_q      <= nmi_d;
        end
    end

    assign irq_pending    = pending_q;
    assign cpu_irq_req    = (state_q == S_REQ);
    assign irq_in_service = (state_q == S_SERVICE);
    assign irq_vector     = vector_q;
    assign cpu_nmi_req    = nmi_q;

endmodule

// File: tb/tb_fc8_vectored_irq_ctrl.sv
// Directed bench for fc8_vectored_irq_ctrl: a per-cycle vector table for
// the IRQ/NMI handshake plus hand-written reset and timer sequences.
module tb_fc8_vectored_irq_ctrl;

    logic        clk_cpu = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_src, irq_enable, irq_clear;
    logic        nmi_src, timer_enable, cpu_irq_ack, cpu_irq_eoi, cpu_nmi_ack;
    logic [3:0]  timer_prescale;
    logic [15:0] timer_reload;
    logic [7:0]  irq_pending;
    logic        cpu_irq_req, cpu_nmi_req, irq_in_service;
    logic [3:0]  irq_vector;
    logic [15:0] timer_count;

    int n_vec  = 0;
    int n_fail = 0;

    fc8_vectored_irq_ctrl #(.NUM_IRQ(8), .TIMER_W(16)) dut (
        .clk_cpu(clk_cpu), .rst_n(rst_n), .irq_src(irq_src), .nmi_src(nmi_src),
        .irq_enable(irq_enable), .irq_clear(irq_clear), .timer_enable(timer_enable),
        .timer_prescale(timer_prescale), .timer_reload(timer_reload),
        .cpu_irq_ack(cpu_irq_ack), .cpu_irq_eoi(cpu_irq_eoi), .cpu_nmi_ack(cpu_nmi_ack),
        .irq_pending(irq_pending), .cpu_irq_req(cpu_irq_req), .cpu_nmi_req(cpu_nmi_req),
        .irq_vector(irq_vector), .irq_in_service(irq_in_service), .timer_count(timer_count)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        logic [7:0] src, en, clr;
        logic       ack, eoi, nmi, nack;
        logic [7:0] pend;
        logic       req;
        logic [3:0] vec;
        logic       svc, nmo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] src, en, clr,
                                input logic ack, eoi, nmi, nack,
                                input logic [7:0] pend, input logic req,
                                input logic [3:0] vec, input logic svc, nmo);
        vec_t v;
        v.src = src; v.en = en; v.clr = clr;
        v.ack = ack; v.eoi = eoi; v.nmi = nmi; v.nack = nack;
        v.pend = pend; v.req = req; v.vec = vec; v.svc = svc; v.nmo = nmo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pend"}, 32'(irq_pending), 32'd0);
        check({tag, " req"}, 32'(cpu_irq_req), 32'd0);
        check({tag, " nmi"}, 32'(cpu_nmi_req), 32'd0);
        check({tag, " vec"}, 32'(irq_vector), 32'd0);
        check({tag, " svc"}, 32'(irq_in_service), 32'd0);
        check({tag, " tcnt"}, 32'(timer_count), 32'd0);
    endtask

    initial begin
        logic got;
        logic any_req;
        int   first_rise, second_rise, nrise;
        logic prev_p0;
        logic [15:0] exp_cnt [16];

        rst_n = 1'b0; irq_src = '0; irq_enable = '0; irq_clear = '0;
        nmi_src = 0; timer_enable = 0; timer_prescale = 0; timer_reload = 0;
        cpu_irq_ack = 0; cpu_irq_eoi = 0; cpu_nmi_ack = 0;

        //        src    en     clr    ack eoi nmi nack  pend   req vec svc nmi
        tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(8'h24, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(8'h24, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h24, 0, 0, 0, 0));
        tbl.push_back(mk(8'h24, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h24, 1, 2, 0, 0));
        tbl.push_back(mk(8'h24, 8'hFF, 8'h00, 1, 0, 0, 0, 8'h20, 0, 2, 1, 0));
        tbl.push_back(mk(8'h24, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h20, 0, 2, 1, 0));
        tbl.push_back(mk(8'h24, 8'hFF, 8'h00, 0, 1, 0, 0, 8'h20, 0, 2, 0, 0));
        tbl.push_back(mk(8'h24, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h20, 1, 5, 0, 0));
        tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 8'h00, 0, 5, 1, 0));
        tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 0, 1, 0, 0, 8'h00, 0, 5, 0, 0));
        tbl.push_back(mk(8'h08, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 5, 0, 0));
        tbl.push_back(mk(8'h08, 8'hFF, 8'h08, 0, 0, 0, 0, 8'h08, 0, 5, 0, 0));
        tbl.push_back(mk(8'h08, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h08, 1, 3, 0, 0));
        tbl.push_back(mk(8'h08, 8'hFF, 8'h08, 0, 0, 0, 0, 8'h00, 1, 3, 0, 0));
        tbl.push_back(mk(8'h08, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 3, 0, 0));
        tbl.push_back(mk(8'h18, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 3, 0, 0));
        tbl.push_back(mk(8'h18, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h10, 0, 3, 0, 0));
        tbl.push_back(mk(8'h18, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h10, 1, 4, 0, 0));
        tbl.push_back(mk(8'h18, 8'hFF, 8'h10, 0, 1, 0, 0, 8'h00, 1, 4, 0, 0));
        tbl.push_back(mk(8'h18, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(8'h19, 8'hFE, 8'h00, 0, 0, 0, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(8'h19, 8'hFE, 8'h00, 0, 0, 0, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(8'h19, 8'hFE, 8'h00, 0, 0, 0, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h02, 0, 4, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFD, 8'h00, 0, 0, 0, 0, 8'h02, 0, 4, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFD, 8'h00, 0, 0, 0, 0, 8'h02, 0, 4, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h02, 1, 1, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h02, 0, 0, 0, 0, 8'h00, 1, 1, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 1, 1, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 1, 1, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(8'h1B, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0));

        // Reset values while rst_n is low.
        #12;
        check_all_zero("reset");
        @(negedge clk_cpu);
        rst_n = 1'b1;

        // Table: inputs driven at negedge, outputs checked just after posedge.
        foreach (tbl[i]) begin
            @(negedge clk_cpu);
            irq_src = tbl[i].src; irq_enable = tbl[i].en; irq_clear = tbl[i].clr;
            cpu_irq_ack = tbl[i].ack; cpu_irq_eoi = tbl[i].eoi;
            nmi_src = tbl[i].nmi; cpu_nmi_ack = tbl[i].nack;
            @(posedge clk_cpu);
            #1;
            check($sformatf("row%0d pend", i), 32'(irq_pending), 32'(tbl[i].pend));
            check($sformatf("row%0d req", i), 32'(cpu_irq_req), 32'(tbl[i].req));
            check($sformatf("row%0d vec", i), 32'(irq_vector), 32'(tbl[i].vec));
            check($sformatf("row%0d svc", i), 32'(irq_in_service), 32'(tbl[i].svc));
            check($sformatf("row%0d nmi", i), 32'(cpu_nmi_req), 32'(tbl[i].nmo));
        end

        // Reset during SERVICE: everything clears and nothing is requested afterwards.
        @(negedge clk_cpu);
        irq_src = 8'h40; irq_clear = '0; cpu_irq_ack = 0; cpu_irq_eoi = 0; cpu_nmi_ack = 0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk_cpu);
            #1;
            if (cpu_irq_req) got = 1'b1;
        end
        check("svc_reset req wait", 32'(got), 32'd1);
        @(negedge clk_cpu);
        cpu_irq_ack = 1'b1;
        @(posedge clk_cpu);
        #1;
        check("svc_reset in_service", 32'(irq_in_service), 32'd1);
        check("svc_reset vec", 32'(irq_vector), 32'd6);
        @(negedge clk_cpu);
        cpu_irq_ack = 1'b0;
        irq_src = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("svc_reset during");
        @(negedge clk_cpu);
        rst_n = 1'b1;
        any_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_cpu);
            #1;
            if (cpu_irq_req || irq_pending != 0 || irq_in_service) any_req = 1'b1;
        end
        check("svc_reset no spurious", 32'(any_req), 32'd0);

        // Source held high through reset release yields exactly one edge.
        @(negedge clk_cpu);
        rst_n = 1'b0;
        irq_src = 8'h80;
        @(negedge clk_cpu);
        rst_n = 1'b1;
        @(posedge clk_cpu);
        @(posedge clk_cpu);
        #1;
        check("held_src pend", 32'(irq_pending), 32'h80);
        check("held_src req early", 32'(cpu_irq_req), 32'd0);
        @(posedge clk_cpu);
        #1;
        check("held_src req", 32'(cpu_irq_req), 32'd1);
        check("held_src vec", 32'(irq_vector), 32'd7);

`ifdef FC8_IRQ_TIMER_EN
        // Timer: prescale 2 (divide by 4), reload 3.
        @(negedge clk_cpu);
        rst_n = 1'b0;
        irq_src = 8'h00;
        timer_prescale = 4'd2; timer_reload = 16'd3; timer_enable = 1'b0;
        @(negedge clk_cpu);
        rst_n = 1'b1;
        @(negedge clk_cpu);
        check("timer disabled holds reload", 32'(timer_count), 32'd3);
        exp_cnt = '{16'd3, 16'd3, 16'd3, 16'd2, 16'd2, 16'd2, 16'd2, 16'd1,
                    16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd3};
        timer_enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk_cpu);
            #1;
            check($sformatf("timer cnt%0d", k), 32'(timer_count), 32'(exp_cnt[k]));
        end
        first_rise = 0; second_rise = 0; nrise = 0; prev_p0 = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_cpu);
            irq_clear = {7'b0, irq_pending[0]};
            @(posedge clk_cpu);
            #1;
            if (irq_pending[0] && !prev_p0) begin
                if (nrise == 0) first_rise = c;
                else if (nrise == 1) second_rise = c;
                nrise++;
            end
            prev_p0 = irq_pending[0];
        end
        check("timer event period", 32'(second_rise - first_rise), 32'd16);
`else
        @(negedge clk_cpu);
        timer_enable = 1'b1; timer_reload = 16'd5; timer_prescale = 4'd0;
        repeat (4) @(posedge clk_cpu);
        #1;
        check("timer absent count", 32'(timer_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fc8_vectored_irq_ctrl.md
FC8_VECTORED_IRQ_CTRL -- requirements
Module: fc8_vectored_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of maskable channels; legal range 2..16.
REQ-002 SHALL have parameter TIMER_W, default 16, timer down-counter width; legal range 8..24.
REQ-003 SHALL have port clk_cpu  in  1  CPU clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port irq_src  in  NUM_IRQ  raw interrupt sources, rising-edge sensitive.
REQ-006 SHALL have port nmi_src  in  1  raw NMI source (graphics NEW_FRAME), rising-edge sensitive.
REQ-007 SHALL have port irq_enable  in  NUM_IRQ  per-channel enable from the SFR block.
REQ-008 SHALL have port irq_clear  in  NUM_IRQ  per-channel write-1-to-clear pulses from the SFR block.
REQ-009 SHALL have port timer_enable  in  1  timer run control.
REQ-010 SHALL have port timer_prescale  in  4  prescaler select N; division 2^min(N,8).
REQ-011 SHALL have port timer_reload  in  TIMER_W  timer reload value.
REQ-012 SHALL have port cpu_irq_ack  in  1  one-cycle IRQ acknowledge from the CPU.
REQ-013 SHALL have port cpu_irq_eoi  in  1  one-cycle end-of-interrupt from the CPU.
REQ-014 SHALL have port cpu_nmi_ack  in  1  one-cycle NMI acknowledge from the CPU.
REQ-015 SHALL have port irq_pending  out  NUM_IRQ  latched pending bits, readable via the SFR block.
REQ-016 SHALL have port cpu_irq_req  out  1  level IRQ request.
REQ-017 SHALL have port cpu_nmi_req  out  1  level NMI request.
REQ-018 SHALL have port irq_vector  out  4  index of the presented or in-service channel.
REQ-019 SHALL have port irq_in_service  out  1  high while the controller is in SERVICE.
REQ-020 SHALL have port timer_count  out  TIMER_W  current timer value.

Function
REQ-021 SHALL register irq_src and nmi_src once, then detect a rising edge as (current & ~previous); the edge sets the pending bit on the next clock.
REQ-022 SHALL ignore edges on channels whose irq_enable is 0; a bit that is already pending stays set when its enable drops, but it is excluded from arbitration.
REQ-023 SHALL clear irq_pending[i] on irq_clear[i]; a simultaneous set and clear on the same channel leaves the bit set.
REQ-024 SHALL use fixed priority: lowest index of (irq_pending & irq_enable) wins.
REQ-025 SHALL implement FSM IDLE/REQ/SERVICE.
- IDLE: cpu_irq_req=0; go to REQ when any (pending & enable) bit is set.
REQ-026 REQ state:
- cpu_irq_req=1; irq_vector updates every cycle to the current winner.
- If no enabled pending bit remains, go to IDLE.
- On cpu_irq_ack: clear pending[irq_vector], freeze irq_vector, go to SERVICE.
REQ-027 SERVICE state: cpu_irq_req=0, irq_in_service=1, irq_vector held; go to IDLE on cpu_irq_eoi.
REQ-028 SHALL ignore cpu_irq_ack outside REQ and cpu_irq_eoi outside SERVICE.
REQ-029 SHALL meet IRQ latency: source edge sampled in cycle N; pending visible at N+2; cpu_irq_req and irq_vector valid at N+3.
REQ-030 SHALL set an NMI latch on an nmi_src rising edge; cpu_nmi_req equals the latch; cpu_nmi_ack clears it; a simultaneous edge and ack leaves it set.
- NMI is unmaskable and independent of the IRQ FSM.
REQ-031 SHALL reset each channel's edge-detect history to 0, so a source held high at reset release produces one edge.

Reset
REQ-032 SHALL, on rst_n low, asynchronously set all of the following to 0:
- irq_pending, cpu_irq_req, cpu_nmi_req, irq_vector, irq_in_service, the NMI latch, the edge registers and the prescaler.
- timer_count resets to 0; FSM state resets to IDLE.
REQ-033 SHALL abandon any REQ or SERVICE in progress on reset, without emitting a spurious request afterwards.

Configuration
REQ-034 With macro FC8_IRQ_TIMER_EN defined, the internal timer SHALL drive channel 0 and irq_src[0] SHALL be ignored.
- Timer disabled: timer_count held at timer_reload, prescaler held at 0.
- Timer enabled: timer_count decrements on each prescaler tick.
- Tick at count 0: timer_count reloads and a one-cycle channel-0 event pulse is generated.
- timer_reload=0: an event occurs on every tick.
REQ-035 Without FC8_IRQ_TIMER_EN, the timer logic SHALL be absent, timer_count SHALL be tied to 0, and channel 0 SHALL be driven by irq_src[0].

Verification
REQ-036 Enables all 1; rising edges on channels 5 and 2 in the same cycle -> cpu_irq_req at N+3 with irq_vector=2; after ack -> vector 2 in service; after eoi -> REQ again with vector 5.
REQ-037 irq_clear[3] asserted in the same cycle pending[3] sets -> pending[3] remains 1.
REQ-038 In REQ with only channel 4 pending, irq_clear[4] asserted -> FSM returns to IDLE and cpu_irq_req drops the next cycle.
REQ-039 FC8_IRQ_TIMER_EN defined, timer_prescale=2, timer_reload=3, enable set -> channel-0 event every 16 cycles; timer_count sequence 3,2,1,0,3.
REQ-040 nmi_src edge with cpu_nmi_ack in the same cycle -> cpu_nmi_req stays 1; ack alone -> 0 the next cycle.
REQ-041 rst_n pulsed low during SERVICE -> all outputs 0 and state IDLE; no request after release unless a new edge occurs.
